// File: rtl/seven_seg_pkg.sv
// Shared constants for the four-digit seven-segment serial display driver.
package seven_seg_pkg;

    localparam int FRAME_W    = 16;
    localparam int NUM_DIGITS = 4;
    localparam int LATCH_CNT  = 16;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segments {dp,g,f,e,d,c,b,a}; non-decimal codes show blank.
    localparam logic [7:0] SEG_LUT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        SEG_BLANK, SEG_BLANK
    };

endpackage

// File: rtl/seven_seg_dcd_bin_to_bcd.sv
// Combinational double-dabble conversion of a 16-bit value to its low four BCD digits.
module bin_to_bcd (
    input  logic [15:0] bin_i,
    output logic [3:0]  ones_o,
    output logic [3:0]  tens_o,
    output logic [3:0]  hundreds_o,
    output logic [3:0]  thousands_o
);

    logic [31:0] sh;

    // Only four BCD columns are kept; carries out of the thousands column fall
    // off the top, which leaves the lower digits equal to bin mod 10000.
    always_comb begin
        sh = {16'd0, bin_i};
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < 4; d++) begin
                if (sh[16 + 4*d +: 4] >= 4'd5) begin
                    sh[16 + 4*d +: 4] = sh[16 + 4*d +: 4] + 4'd3;
                end
            end
            sh = sh << 1;
        end
    end

    assign ones_o      = sh[19:16];
    assign tens_o      = sh[23:20];
    assign hundreds_o  = sh[27:24];
    assign thousands_o = sh[31:28];

endmodule

// File: rtl/seven_seg_dcd.sv
// Four-digit seven-segment driver: BCD conversion, digit encode and serial frame shifter.
module seven_seg_dcd
    import seven_seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bin,
    output logic        seg_data,
    output logic        seg_latch,
    output logic [15:0] bcd
);

    logic [4:0]                      cnt_q, cnt_d;
    logic [FRAME_W-1:0]              shreg_q, shreg_d;
    logic [$clog2(NUM_DIGITS)-1:0]   idx_q, idx_d;

    logic [3:0]         ones, tens, hundreds, thousands;
    logic [3:0]         digit_sel;
    logic [7:0]         seg_code;
    logic [7:0]         ctrl_code;
    logic [FRAME_W-1:0] frame;

    bin_to_bcd u_bin_to_bcd (
        .bin_i       (bin),
        .ones_o      (ones),
        .tens_o      (tens),
        .hundreds_o  (hundreds),
        .thousands_o (thousands)
    );

    assign bcd = {thousands, hundreds, tens, ones};

    always_comb begin
        digit_sel = ones;
        case (idx_q)
            2'd0:    digit_sel = ones;
            2'd1:    digit_sel = tens;
            2'd2:    digit_sel = hundreds;
            default: digit_sel = thousands;
        endcase
        seg_code  = SEG_LUT[digit_sel];
        ctrl_code = ~(8'd1 << idx_q);
        frame     = {seg_code, ctrl_code};
    end

    // Shift ones in behind the data so an idle line reads high.
    always_comb begin
        cnt_d   = cnt_q + 5'd1;
        shreg_d = {shreg_q[FRAME_W-2:0], 1'b1};
        idx_d   = idx_q;
        if (cnt_q == 5'(LATCH_CNT)) begin
            cnt_d   = 5'd0;
            shreg_d = frame;
            idx_d   = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 5'd0;
            shreg_q <= {FRAME_W{1'b1}};
            idx_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign seg_data  = shreg_q[FRAME_W-1];
    assign seg_latch = (cnt_q == 5'(LATCH_CNT));

endmodule

// File: tb/tb_seven_seg_dcd.sv
// Directed-vector bench for the seven-segment serial display driver.
module tb_seven_seg_dcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bin = 16'd0;
    logic        seg_data;
    logic        seg_latch;
    logic [15:0] bcd;

    int n_checks = 0;
    int n_pass   = 0;

    seven_seg_dcd dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bin       (bin),
        .seg_data  (seg_data),
        .seg_latch (seg_latch),
        .bcd       (bcd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench sampling cycle 0 (cnt = 0) after release.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Collects one 17-cycle frame starting at its cnt = 0 cycle.
    task automatic get_frame(output logic [15:0] f, output int bad_latch, output logic latch_seen);
        f = 16'h0;
        bad_latch = 0;
        for (int i = 0; i < 16; i++) begin
            f = {f[14:0], seg_data};
            if (seg_latch !== 1'b0) bad_latch++;
            tick();
        end
        latch_seen = seg_latch;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] f;
        int          bad;
        logic        lat;
        logic [15:0] exp_f [5] = '{16'hC0FE, 16'hC0FD, 16'hC0FB, 16'hC0F7, 16'hC0FE};
        bin = 16'd0;
        do_reset();
        n_checks++;
        if (seg_data !== 1'b1 || seg_latch !== 1'b0)
            $display("FAIL reset_outputs: got data=%b latch=%b want data=1 latch=0", seg_data, seg_latch);
        else n_pass++;
        n_checks++;
        if (bcd !== 16'h0000) $display("FAIL reset_bcd: got %h want 0000", bcd);
        else n_pass++;
        get_frame(f, bad, lat);
        n_checks++;
        if (f !== 16'hFFFF || bad != 0 || lat !== 1'b1)
            $display("FAIL blank_frame: got %h bad=%0d latch=%b want FFFF bad=0 latch=1", f, bad, lat);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            get_frame(f, bad, lat);
            n_checks++;
            if (f !== exp_f[k] || bad != 0 || lat !== 1'b1)
                $display("FAIL zero_frame%0d: got %h bad=%0d latch=%b want %h bad=0 latch=1",
                         k, f, bad, lat, exp_f[k]);
            else n_pass++;
        end
    endtask

    task automatic test_1234();
        logic [15:0] f;
        int          bad;
        logic        lat;
        logic [15:0] exp_f [4] = '{16'h99FE, 16'hB0FD, 16'hA4FB, 16'hF9F7};
        bin = 16'd1234;
        do_reset();
        #1;
        n_checks++;
        if (bcd !== 16'h1234) $display("FAIL bcd_1234: got %h want 1234", bcd);
        else n_pass++;
        get_frame(f, bad, lat);
        for (int k = 0; k < 4; k++) begin
            get_frame(f, bad, lat);
            n_checks++;
            if (f !== exp_f[k] || bad != 0 || lat !== 1'b1)
                $display("FAIL f1234_%0d: got %h bad=%0d latch=%b want %h bad=0 latch=1",
                         k, f, bad, lat, exp_f[k]);
            else n_pass++;
            if (k == 0) begin
                n_checks++;
                if (f !== 16'b1001100111111110)
                    $display("FAIL serial_bits_1234: got %b want 1001100111111110", f);
                else n_pass++;
            end
        end
    endtask

    task automatic test_max();
        logic [15:0] f;
        int          bad;
        logic        lat;
        logic [15:0] exp_f [4] = '{16'h92FE, 16'hB0FD, 16'h92FB, 16'h92F7};
        bin = 16'd65535;
        do_reset();
        #1;
        n_checks++;
        if (bcd !== 16'h5535) $display("FAIL bcd_65535: got %h want 5535", bcd);
        else n_pass++;
        bin = 16'd10000;
        #1;
        n_checks++;
        if (bcd !== 16'h0000) $display("FAIL bcd_10000: got %h want 0000", bcd);
        else n_pass++;
        bin = 16'd9090;
        #1;
        n_checks++;
        if (bcd !== 16'h9090) $display("FAIL bcd_9090: got %h want 9090", bcd);
        else n_pass++;
        bin = 16'd65535;
        get_frame(f, bad, lat);
        for (int k = 0; k < 4; k++) begin
            get_frame(f, bad, lat);
            n_checks++;
            if (f !== exp_f[k] || bad != 0 || lat !== 1'b1)
                $display("FAIL fmax_%0d: got %h bad=%0d latch=%b want %h bad=0 latch=1",
                         k, f, bad, lat, exp_f[k]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_change();
        logic [15:0] f;
        int          bad;
        logic        lat;
        bin = 16'd9999;
        do_reset();
        get_frame(f, bad, lat);
        f = 16'h0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) bin = 16'd1;
            f = {f[14:0], seg_data};
            tick();
        end
        n_checks++;
        if (seg_latch !== 1'b1) $display("FAIL mid_latch: got %b want 1", seg_latch);
        else n_pass++;
        tick();
        n_checks++;
        if (f !== 16'h90FE) $display("FAIL mid_frame: got %h want 90FE", f);
        else n_pass++;
        n_checks++;
        if (bcd !== 16'h0001) $display("FAIL bcd_0001: got %h want 0001", bcd);
        else n_pass++;
        get_frame(f, bad, lat);
        n_checks++;
        if (f !== 16'hC0FD || bad != 0 || lat !== 1'b1)
            $display("FAIL next_frame: got %h bad=%0d latch=%b want C0FD bad=0 latch=1", f, bad, lat);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] f;
        int          bad;
        logic        lat;
        bin = 16'd1234;
        do_reset();
        get_frame(f, bad, lat);
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg_data !== 1'b1 || seg_latch !== 1'b0)
            $display("FAIL rst_cnt9: got data=%b latch=%b want data=1 latch=0", seg_data, seg_latch);
        else n_pass++;
        do_reset();
        get_frame(f, bad, lat);
        n_checks++;
        if (f !== 16'hFFFF || bad != 0 || lat !== 1'b1)
            $display("FAIL rst_blank: got %h bad=%0d latch=%b want FFFF bad=0 latch=1", f, bad, lat);
        else n_pass++;
        get_frame(f, bad, lat);
        n_checks++;
        if (f !== 16'h99FE || bad != 0 || lat !== 1'b1)
            $display("FAIL rst_resume: got %h bad=%0d latch=%b want 99FE bad=0 latch=1", f, bad, lat);
        else n_pass++;
        // Tens frame B0FD: bit 14 (cnt = 1) is 0, and cnt = 16 is the latch cycle.
        tick();
        n_checks++;
        if (seg_data !== 1'b0) $display("FAIL pre_rst_data: got %b want 0", seg_data);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg_data !== 1'b1) $display("FAIL rst_data_now: got %b want 1", seg_data);
        else n_pass++;
        do_reset();
        repeat (16) tick();
        n_checks++;
        if (seg_latch !== 1'b1) $display("FAIL pre_rst_latch: got %b want 1", seg_latch);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg_latch !== 1'b0 || seg_data !== 1'b1)
            $display("FAIL rst_latch_now: got data=%b latch=%b want data=1 latch=0", seg_data, seg_latch);
        else n_pass++;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_1234();
        test_max();
        test_mid_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_dcd.md
# seven_seg_dcd

Four-digit seven-segment display driver. It converts a 16-bit binary value to four BCD digits and encodes each digit into a 16-bit frame (segment pattern plus digit select). It shifts the frames out MSB-first on a serial data line, with a latch pulse after each frame, to an external shift-register display. It sits between the CPU datapath value to display and the board's serial 7-segment interface.

## Interface
- No parameters; widths are fixed (16-bit input, 4 digits, 16-bit frame).
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bin  input  16  unsigned value to display.
- seg_data  output  1  serial frame data, MSB first.
- seg_latch  output  1  one-cycle-high latch strobe after each 16-bit frame.
- bcd  output  16  combinational BCD of bin: {thousands, hundreds, tens, ones}, 4 bits each.

## Operation
- BCD conversion is combinational (double dabble) and shows bin mod 10000. The ten-thousands digit is dropped, so 65535 gives 0x5535.
- Digit encoding uses active-low segments, bit order {dp,g,f,e,d,c,b,a}, with dp always off (1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - codes 10–15=FF (blank)
- Digit select control byte is active-low one-hot: index k gives 8'hFF with bit k cleared.
  - idx0 = ones, FE
  - idx1 = tens, FD
  - idx2 = hundreds, FB
  - idx3 = thousands, F7
  - bits 7:4 are always 1.
- Frame = {segments[7:0], control[7:0]}.
- State:
  - cnt, 5 bits, 0..16
  - shreg, 16 bits
  - digit index idx, 2 bits
- seg_data = shreg[15]; seg_latch = (cnt==16). Both are decoded from registers, so they are glitch-free.
- Rising-edge behaviour:
  - cnt 0..15: shreg <= {shreg[14:0],1'b1}; cnt++.
  - cnt==16: shreg <= frame(idx) built from the current bin; idx++ (wraps 3→0); cnt <= 0.
- bin is sampled only at the frame load. Changes mid-frame do not affect the frame being shifted.
- Reset (async, any time, including mid-frame):
  - cnt=0, shreg=16'hFFFF, idx=0
  - so seg_latch=0 and seg_data=1 immediately
  - the first frame after reset is a blank all-ones frame.

## Timing
- Frame period is 17 cycles: 16 data cycles plus 1 latch cycle.
- In a cycle with cnt=i (i≤15), seg_data holds frame bit 15−i for the whole cycle.
- Number the cycles from reset release as 0; cycle k has cnt=k.
  - Cycle 16: latch of the blank frame.
  - Cycles 17–32: digit 0 (ones) bits; cycle 33: its latch.
  - Latches for tens, hundreds, thousands at cycles 50, 67, 84.
  - Digit 0 latches again at cycle 101.
- Latency from a bin change to its display: at most 4×17 + 17 cycles (the next load of each digit).
- bcd output has zero-cycle latency (combinational).

## Structure
- Package seven_seg_pkg:
  - constants FRAME_W=16, NUM_DIGITS=4, LATCH_CNT=16
  - the 16-entry segment lookup constant
  - the blank pattern 8'hFF
- One sub-module, bin_to_bcd: combinational, 16-bit in, four 4-bit digits out.
- Digit encode and serializer stay in the top module.

## Test plan
- bin=0 after reset:
  - first latched frame is FFFF
  - then frames C0FE, C0FD, C0FB, C0F7 at latches 33/50/67/84, repeating.
- bin=1234:
  - bcd=0x1234
  - frames 99FE, B0FD, A4FB, F9F7
  - seg_data during the digit-0 data cycles = 1001100111111110.
- bin=65535: bcd=0x5535; frames 92FE, B0FD, 92FB, 92F7.
- bin=9999 changed to 0001 at cnt=5 of the ones frame:
  - current frame still 90FE
  - next loads use the new value (tens frame C0FD).
- Assert rst_n low at cnt=9 of a frame:
  - seg_latch=0 and seg_data=1 immediately
  - after release the blank frame FFFF latches at cycle 16, then ones digit resumes at idx0.
- Check in every frame:
  - seg_latch is high exactly 1 cycle in 17
  - never high during data cycles.
